// File: rtl/pcie_drp_arbiter_pkg.sv
// Shared types and constants for the PCIE_2_1 DRP port arbiter.
// Widths match the hard block's DRPADDR/DRPDI/DRPDO ports.
package pcie_drp_pkg;

  localparam int DRP_AW          = 9;
  localparam int DRP_DW          = 16;
  localparam int DEFAULT_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } drp_state_e;

endpackage

// File: rtl/pcie_drp_arbiter_if.sv
// Requester handshake plus DRP bus bundle for pcie_drp_arbiter.
// The slave modport is the arbiter's view; master is the user/hard-block side.
interface pcie_drp_arbiter_if
  import pcie_drp_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = DRP_AW,
  parameter int DW   = DRP_DW
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;
  logic               rsp_err;
  logic               busy;
  logic               drp_en;
  logic               drp_we;
  logic [AW-1:0]      drp_addr;
  logic [DW-1:0]      drp_di;
  logic [DW-1:0]      drp_do;
  logic               drp_rdy;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, drp_do, drp_rdy,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
           drp_en, drp_we, drp_addr, drp_di
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, drp_do, drp_rdy,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
           drp_en, drp_we, drp_addr, drp_di
  );

endinterface

// File: rtl/pcie_drp_arbiter_rr_arbiter.sv
// Round-robin grant selection; the only state is the priority pointer,
// which moves just past the winner whenever a grant is taken.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NREQ-1:0]                         req,
  input  logic                                    advance,
  output logic [NREQ-1:0]                         grant,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] grant_idx
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0] ptr_reg;

  // Scan from the pointer upwards, wrapping; the first valid requester wins.
  always_comb begin
    logic found;
    int   idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_reg) + k) % NREQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= '0;
    end else if (advance) begin
      ptr_reg <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/pcie_drp_arbiter.sv
// Shares the PCIE_2_1 DRP port between NREQ requesters: round-robin grant,
// one EN pulse per transaction, RDY wait with timeout abort, one-cycle response.
module pcie_drp_arbiter
  import pcie_drp_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int AW      = DRP_AW,
  parameter int DW      = DRP_DW,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  sys_rst_n,
  pcie_drp_arbiter_if.slave     bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  drp_state_e    state_reg, state_next;
  logic          accept, rdy_hit, timeout_hit;
  logic [NREQ-1:0] grant;
  logic [IW-1:0] grant_idx;

  logic          we_reg;
  logic [AW-1:0] addr_reg;
  logic [DW-1:0] wdata_reg;
  logic [IW-1:0] grant_reg;
  logic [CW-1:0] cnt_reg;
  logic [DW-1:0] rdata_reg;
  logic          err_reg;

  assign accept      = (state_reg == IDLE) && (|bus.req_valid);
  assign rdy_hit     = (state_reg == WAIT) && bus.drp_rdy;
  // RDY on the final timeout cycle still counts as a completion.
  assign timeout_hit = (state_reg == WAIT) && !bus.drp_rdy
                       && (cnt_reg == CW'(TIMEOUT - 1));

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk       (clk),
    .rst_n     (sys_rst_n),
    .req       (bus.req_valid),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (rdy_hit || timeout_hit) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      grant_reg <= '0;
      cnt_reg   <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      if (accept) begin
        we_reg    <= bus.req_we[grant_idx];
        addr_reg  <= bus.req_addr[grant_idx*AW +: AW];
        wdata_reg <= bus.req_wdata[grant_idx*DW +: DW];
        grant_reg <= grant_idx;
      end
      if (state_reg == ISSUE) begin
        cnt_reg <= '0;
      end else if (state_reg == WAIT && cnt_reg != '1) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (rdy_hit) begin
        rdata_reg <= bus.drp_do;
        err_reg   <= 1'b0;
      end else if (timeout_hit) begin
        rdata_reg <= '0;
        err_reg   <= 1'b1;
      end
    end
  end

  // req_ready is masked by reset so nothing is offered while held in reset.
  always_comb begin
    bus.req_ready = (state_reg == IDLE && sys_rst_n) ? grant : '0;
    bus.rsp_valid = (state_reg == RESP) ? (NREQ'(1) << grant_reg) : '0;
    bus.rsp_rdata = rdata_reg;
    bus.rsp_err   = err_reg;
    bus.busy      = (state_reg != IDLE);
    bus.drp_en    = (state_reg == ISSUE);
    bus.drp_we    = (state_reg == ISSUE) && we_reg;
    bus.drp_addr  = addr_reg;
    bus.drp_di    = wdata_reg;
  end

endmodule
